// File: rtl/kb_pkg.sv
// Shared constants for the PS/2 multi-key decoder: FSM encoding, prefix bytes,
// discarded bytes and the default key table.
package kb_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] EXT     = 2'd1;
  localparam logic [1:0] BRK     = 2'd2;
  localparam logic [1:0] EXT_BRK = 2'd3;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  localparam int unsigned NUM_IGNORED = 7;
  localparam logic [NUM_IGNORED*8-1:0] IGNORED_BYTES =
    {8'hE1, 8'hFF, 8'h00, 8'hEE, 8'hFE, 8'hFA, 8'hAA};

  localparam int unsigned DEFAULT_NUM_KEYS = 6;
  localparam logic [DEFAULT_NUM_KEYS*9-1:0] DEFAULT_KEY_CODES =
    {9'h05A, 9'h02D, 9'h01B, 9'h01D, 9'h023, 9'h01C};

  function automatic logic is_ignored_byte(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    for (int unsigned i = 0; i < NUM_IGNORED; i++) begin
      if (b == IGNORED_BYTES[i*8 +: 8]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/kb_scan_decoder.sv
// Set-2 scan-code sequence decoder: tracks E0/F0 prefixes, abandons stale
// prefixes after a timeout, and emits one make/break event per terminal byte.
module kb_scan_decoder
  import kb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 2_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scan_done_tick,
  input  logic [7:0] scan_code,
  input  logic       clear,
  output logic       evt_valid,
  output logic       evt_break,
  output logic [8:0] evt_code
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    evt_valid = 1'b0;
    evt_break = 1'b0;
    evt_code  = '0;
    if (clear) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (scan_done_tick) begin
      cnt_d = '0;
      if (scan_code == PS2_EXT) begin
        state_d = EXT;
      end else if (scan_code == PS2_BRK) begin
        if (state_q == IDLE)     state_d = BRK;
        else if (state_q == EXT) state_d = EXT_BRK;
      end else if (is_ignored_byte(scan_code)) begin
        state_d = IDLE;
      end else begin
        // Encoding puts the E0 flag in bit 0 and the F0 flag in bit 1.
        evt_valid = 1'b1;
        evt_break = state_q[1];
        evt_code  = {state_q[0], scan_code};
        state_d   = IDLE;
      end
    end else if (state_q != IDLE) begin
      if (cnt_q == CNT_LAST) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/kb_key_bank.sv
// Multi-key PS/2 keyboard tracker: one shared sequence decoder feeding a bank
// of per-key held/press/release registers with typematic repeats suppressed.
module kb_key_bank
  import kb_pkg::*;
#(
  parameter int unsigned              NUM_KEYS       = DEFAULT_NUM_KEYS,
  parameter logic [NUM_KEYS*9-1:0]    KEY_CODES      = DEFAULT_KEY_CODES,
  parameter int unsigned              TIMEOUT_CYCLES = 2_500_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                scan_done_tick,
  input  logic [7:0]          scan_code,
  input  logic                clear,
  output logic [NUM_KEYS-1:0] key_down,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                any_down
);

  logic       evt_valid;
  logic       evt_break;
  logic [8:0] evt_code;

  kb_scan_decoder #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_decoder (
    .clk           (clk),
    .reset         (reset),
    .scan_done_tick(scan_done_tick),
    .scan_code     (scan_code),
    .clear         (clear),
    .evt_valid     (evt_valid),
    .evt_break     (evt_break),
    .evt_code      (evt_code)
  );

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
    logic hit;
    logic down_q, press_q, release_q;

    assign hit = evt_valid && (evt_code == KEY_CODES[gi*9 +: 9]);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        down_q    <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        if (clear) begin
          if (down_q) begin
            down_q    <= 1'b0;
            release_q <= 1'b1;
          end
        end else if (hit) begin
          if (!evt_break && !down_q) begin
            down_q  <= 1'b1;
            press_q <= 1'b1;
          end else if (evt_break && down_q) begin
            down_q    <= 1'b0;
            release_q <= 1'b1;
          end
        end
      end
    end

    assign key_down[gi]    = down_q;
    assign key_press[gi]   = press_q;
    assign key_release[gi] = release_q;
  end

  assign any_down = |key_down;

endmodule

// File: tb/tb_kb_key_bank.sv
// Directed bench for kb_key_bank: default six keys plus an extended 0x175 entry
// at index 6, with a short prefix timeout.
module tb_kb_key_bank;

  logic       clk;
  logic       reset;
  logic       scan_done_tick;
  logic [7:0] scan_code;
  logic       clear;
  logic [6:0] key_down;
  logic [6:0] key_press;
  logic [6:0] key_release;
  logic       any_down;

  int tests;
  int failed;

  kb_key_bank #(
    .NUM_KEYS      (7),
    .KEY_CODES     ({9'h175, 9'h05A, 9'h02D, 9'h01B, 9'h01D, 9'h023, 9'h01C}),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .scan_done_tick(scan_done_tick),
    .scan_code     (scan_code),
    .clear         (clear),
    .key_down      (key_down),
    .key_press     (key_press),
    .key_release   (key_release),
    .any_down      (any_down)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge; returns at the next negedge, just after the capture edge.
  task automatic send(input logic [7:0] b);
    scan_code      = b;
    scan_done_tick = 1'b1;
    @(negedge clk);
    scan_done_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [6:0] p, input logic [6:0] r,
                     input logic [6:0] d);
    tests++;
    assert (key_press === p) else begin
      failed++;
      $error("FAIL %s key_press observed %b expected %b", tag, key_press, p);
    end
    tests++;
    assert (key_release === r) else begin
      failed++;
      $error("FAIL %s key_release observed %b expected %b", tag, key_release, r);
    end
    tests++;
    assert (key_down === d) else begin
      failed++;
      $error("FAIL %s key_down observed %b expected %b", tag, key_down, d);
    end
    tests++;
    assert (any_down === (|d)) else begin
      failed++;
      $error("FAIL %s any_down observed %b expected %b", tag, any_down, |d);
    end
  endtask

  initial begin
    tests = 0;
    failed = 0;
    reset = 1'b1;
    scan_done_tick = 1'b0;
    scan_code = 8'h00;
    clear = 1'b0;
    idle(3);
    reset = 1'b0;
    chk("reset", 7'h00, 7'h00, 7'h00);

    // Make and break of key 0
    send(8'h1C);  chk("make0",      7'h01, 7'h00, 7'h01);
    idle(1);      chk("make0_hold", 7'h00, 7'h00, 7'h01);
    send(8'hF0);  chk("f0_prefix",  7'h00, 7'h00, 7'h01);
    send(8'h1C);  chk("brk0",       7'h00, 7'h01, 7'h00);
    idle(1);      chk("brk0_after", 7'h00, 7'h00, 7'h00);

    // Typematic repeat on key 1
    send(8'h23);  chk("rep1_a",   7'h02, 7'h00, 7'h02);
    send(8'h23);  chk("rep1_b",   7'h00, 7'h00, 7'h02);
    send(8'h23);  chk("rep1_c",   7'h00, 7'h00, 7'h02);
    send(8'hF0);
    send(8'h23);  chk("rep1_brk", 7'h00, 7'h02, 7'h00);

    // Extended versus plain code for the 0x175 entry
    send(8'hE0);
    send(8'h75);  chk("ext_make",   7'h40, 7'h00, 7'h40);
    send(8'h75);  chk("plain_75",   7'h00, 7'h00, 7'h40);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);  chk("ext_brk",    7'h00, 7'h40, 7'h00);

    // E0 after F0 restarts the sequence as an extended make
    send(8'hF0);
    send(8'hE0);
    send(8'h75);  chk("e0_restart", 7'h40, 7'h00, 7'h40);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);  chk("e0_rel",     7'h00, 7'h40, 7'h00);

    // Ignored byte aborts a pending break
    send(8'hF0);
    send(8'hAA);
    send(8'h1C);  chk("ign_make",   7'h01, 7'h00, 7'h01);
    send(8'hF0);
    send(8'h1C);  chk("ign_rel",    7'h00, 7'h01, 7'h00);

    // Stale F0 times out: the next 1C is a make
    send(8'hF0);
    idle(20);
    send(8'h1C);  chk("tmo_make",   7'h01, 7'h00, 7'h01);
    // Short gap keeps the F0 alive: break
    send(8'hF0);
    idle(14);
    send(8'h1C);  chk("tmo_live",   7'h00, 7'h01, 7'h00);

    // Clear beats a same-cycle 23 tick
    send(8'h1C);
    send(8'h5A);  chk("pre_clear",  7'h20, 7'h00, 7'h21);
    scan_code = 8'h23;
    scan_done_tick = 1'b1;
    clear = 1'b1;
    @(negedge clk);
    scan_done_tick = 1'b0;
    clear = 1'b0;
    chk("clear",       7'h00, 7'h21, 7'h00);
    idle(1);      chk("clear_after", 7'h00, 7'h00, 7'h00);

    // Clear aborts a pending F0
    send(8'hF0);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    send(8'h1C);  chk("clear_abort", 7'h01, 7'h00, 7'h01);

    // Reset mid-sequence, with key 0 down: no release pulses
    send(8'hE0);
    send(8'hF0);
    reset = 1'b1;
    #1;
    chk("rst_async", 7'h00, 7'h00, 7'h00);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_done",  7'h00, 7'h00, 7'h00);
    send(8'h1D);  chk("post_rst_make", 7'h04, 7'h00, 7'h04);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
